// File: rtl/hold_reg_bank.sv
// hold_reg_bank: CHANNELS independent WIDTH-bit hold registers with
// per-channel load enable, a selectable registered/transparent output,
// and a snapshot engine that streams an atomic copy of all channels.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  0 = registered q, 1 = transparent-when-enabled q
//   en, d, q              per-channel enable, data in, data out (packed)
//   snap_req, snap_busy   snapshot request / stream in progress
//   out_valid, out_ready  snapshot beat handshake
//   out_data, out_ch      beat payload and its channel index
//   out_last              beat carries channel CHANNELS-1
//   drop_cnt              saturating count of requests ignored mid-stream
module hold_reg_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    localparam int IDX_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    input  logic                      snap_req,
    output logic                      snap_busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]          out_ch,
    output logic                      out_last,
    output logic [CNT_W-1:0]          drop_cnt
);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    logic [WIDTH-1:0] r_s    [CHANNELS];
    logic [WIDTH-1:0] r_snap [CHANNELS];
    logic [WIDTH-1:0] w_nxt_s[CHANNELS];

    state_t           r_state;
    state_t           w_state_nx;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [CNT_W-1:0] r_drop;
    logic             w_cap;
    logic             w_stream;
    logic             w_last;
    logic             w_drop_inc;

    // The next stored value doubles as the transparent output and as
    // the snapshot source, so a snapshot sees the post-edge contents.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign w_nxt_s[gi] = en[gi] ? d[gi*WIDTH +: WIDTH] : r_s[gi];
        assign q[gi*WIDTH +: WIDTH] = mode ? w_nxt_s[gi] : r_s[gi];
    end

    assign w_stream = (r_state == S_STREAM);
    assign w_last   = w_stream && (r_idx == LAST_IDX);

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cap      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (snap_req) begin
                    w_state_nx = S_STREAM;
                    w_idx_nx   = '0;
                    w_cap      = 1'b1;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nx = S_IDLE;
                        w_idx_nx   = '0;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
            end
        endcase
    end

    // Requests are only honoured in IDLE; anything seen mid-stream,
    // including on the final acceptance edge, is counted as dropped.
    assign w_drop_inc = w_stream && snap_req && (r_drop != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            if (w_drop_inc) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_s[i]    <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_s[i] <= w_nxt_s[i];
                if (w_cap) begin
                    r_snap[i] <= w_nxt_s[i];
                end
            end
        end
    end

    assign snap_busy = w_stream;
    assign out_valid = w_stream;
    assign out_ch    = r_idx;
    assign out_last  = w_last;
    assign out_data  = w_stream ? r_snap[r_idx] : '0;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_hold_reg_bank.sv
// Testbench for hold_reg_bank: directed scenarios plus random traffic,
// checked against a queue-based reference model and a beat scoreboard.
module tb_hold_reg_bank;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int CW = 2;
    localparam int DMAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         mode = 1'b0;
    logic [C-1:0] en = '0;
    logic [C*W-1:0] d = '0;
    logic [C*W-1:0] q;
    logic         snap_req = 1'b0;
    logic         snap_busy;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   out_ch;
    logic         out_last;
    logic [CW-1:0] drop_cnt;

    hold_reg_bank #(
        .WIDTH   (W),
        .CHANNELS(C),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .en       (en),
        .d        (d),
        .q        (q),
        .snap_req (snap_req),
        .snap_busy(snap_busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_last (out_last),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           ch;
        logic [W-1:0] data;
        bit           last;
    } beat_t;

    beat_t        expq[$];
    logic [W-1:0] m_s[C] = '{default: '0};
    int           m_pending = 0;
    int           m_drop = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [C*W-1:0] exp_q();
        logic [C*W-1:0] r;
        for (int i = 0; i < C; i++) begin
            r[i*W +: W] = (mode && en[i]) ? d[i*W +: W] : m_s[i];
        end
        return r;
    endfunction

    // Reference model: stored values, outstanding beat count, drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C; i++) m_s[i] = '0;
            m_pending = 0;
            m_drop = 0;
            expq.delete();
        end else begin
            for (int i = 0; i < C; i++) begin
                if (en[i]) m_s[i] = d[i*W +: W];
            end
            if (m_pending > 0) begin
                if (snap_req && m_drop < DMAX) m_drop++;
                if (out_ready) m_pending--;
            end else if (snap_req) begin
                for (int i = 0; i < C; i++) begin
                    expq.push_back('{i, m_s[i], i == C - 1});
                end
                m_pending = C;
            end
        end
    end

    // Monitor: compares outputs and pops beats the consumer takes.
    always @(negedge clk) begin
        beat_t b;
        check("q", q, exp_q());
        check("snap_busy", snap_busy, m_pending > 0);
        check("drop_cnt", drop_cnt, m_drop);
        if (out_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat: got unexpected ch %0d expected none",
                         out_ch);
            end else begin
                b = expq[0];
                if (out_ready) void'(expq.pop_front());
                check("out_ch", out_ch, b.ch);
                check("out_data", out_data, b.data);
                check("out_last", out_last, b.last);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(int ch, logic [W-1:0] v, bit last);
        check("beat_valid", out_valid, 1'b1);
        check("beat_ch", out_ch, ch);
        check("beat_data", out_data, v);
        check("beat_last", out_last, last);
    endtask

    initial begin
        logic [W-1:0] vals[C];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", q, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", snap_busy, 0);
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_last", out_last, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;

        // Registered load of channel 0, then hold.
        en = 4'b0001;
        d = 32'h0000_00A5;
        step();
        en = '0;
        d = $urandom;
        check("t1_ch0", q[7:0], 8'hA5);
        check("t1_rest", q[31:8], 0);
        repeat (2) begin
            step();
            d = $urandom;
            check("t1_hold", q, 32'h0000_00A5);
        end

        // Transparent mode follows d with no clock.
        mode = 1'b1;
        en = 4'b0100;
        d[23:16] = 8'h3C;
        #1 check("t2_3c", q[23:16], 8'h3C);
        d[23:16] = 8'hC3;
        #1 check("t2_c3", q[23:16], 8'hC3);
        step();
        en = '0;
        d[23:16] = 8'h55;
        #1 check("t2_held", q[23:16], 8'hC3);
        mode = 1'b0;
        #1 check("t2_mode0", q[23:16], 8'hC3);

        // Full-speed stream.
        en = '1;
        d = 32'h4433_2211;
        step();
        en = '0;
        out_ready = 1'b1;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        for (int k = 0; k < C; k++) begin
            chk_beat(k, vals[k], k == C - 1);
            step();
        end
        check("t3_idle", snap_busy, 0);

        // Back-pressure on beat 1 while channel 1 is reloaded.
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        out_ready = 1'b0;
        en = 4'b0010;
        d[15:8] = 8'h99;
        #1 chk_beat(1, 8'h22, 0);
        step();
        en = '0;
        check("t4_q1", q[15:8], 8'h99);
        repeat (2) begin
            chk_beat(1, 8'h22, 0);
            step();
        end
        out_ready = 1'b1;
        chk_beat(1, 8'h22, 0);
        step();
        chk_beat(2, 8'h33, 0);
        step();
        chk_beat(3, 8'h44, 1);
        step();
        check("t4_idle", snap_busy, 0);

        // Request held through a whole stream: drops saturate.
        snap_req = 1'b1;
        step();
        repeat (C) step();
        check("t5_drop", drop_cnt, DMAX);
        check("t5_idle", snap_busy, 0);
        step();
        check("t5_restart", snap_busy, 1);
        check("t5_ch0", out_ch, 0);
        snap_req = 1'b0;
        repeat (C) step();

        // Reset during beat 2.
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        step();
        check("t6_ch2", out_ch, 2);
        rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_busy", snap_busy, 0);
        check("t6_data", out_data, 0);
        check("t6_ch", out_ch, 0);
        check("t6_last", out_last, 0);
        check("t6_q", q, 0);
        check("t6_drop", drop_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_post_busy", snap_busy, 0);
        check("t6_post_q", q, 0);

        // Random traffic.
        repeat (400) begin
            mode = 1'($urandom);
            en = 4'($urandom);
            d = $urandom;
            snap_req = ($urandom % 8) == 0;
            out_ready = ($urandom % 4) != 0;
            step();
        end
        snap_req = 1'b0;
        out_ready = 1'b1;
        repeat (C + 2) step();
        check("drain", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hold_reg_bank.md
Name: hold_reg_bank

Overview:
- Parametrised, multi-channel successor to the single-bit conditional-hold cell: CHANNELS independent WIDTH-bit hold registers, each with its own enable.
- Selectable output mode: registered, or transparent-when-enabled implemented as mux plus flop (no inferred latch).
- Snapshot engine streams an atomic copy of all channels over a valid/ready port, one channel per beat, for debug and readout logic.

Parameters:
- WIDTH, 8, data bits per channel (>=1)
- CHANNELS, 4, number of hold channels (>=2)
- CNT_W, 8, width of the dropped-request counter (>=1)
- IDX_W, $clog2(CHANNELS), width of the channel index (derived; not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = registered output, 1 = transparent-when-enabled output
- en  input  CHANNELS  per-channel load enable; bit i controls channel i
- d  input  CHANNELS*WIDTH  channel i data on d[i*WIDTH +: WIDTH]
- q  output  CHANNELS*WIDTH  channel i output, same packing as d
- snap_req  input  1  request an atomic snapshot of all channels
- snap_busy  output  1  high while a snapshot is being streamed
- out_valid  output  1  snapshot beat valid
- out_ready  input  1  consumer accepts beat
- out_data  output  WIDTH  snapshot value of channel out_ch
- out_ch  output  IDX_W  channel index of the current beat
- out_last  output  1  current beat is channel CHANNELS-1
- drop_cnt  output  CNT_W  saturating count of ignored snap_req

Behaviour:
- Reset: asynchronous on rst_n low.
  - All stored values s[i] = 0, snapshot buffer = 0.
  - FSM = IDLE, index = 0, drop_cnt = 0.
  - snap_busy, out_valid and out_last = 0; out_data = 0; out_ch = 0.
  - q = 0 in mode 0; in mode 1, q[i] = d[i] when en[i] is high, else 0.
- Store: at each rising edge, if en[i] then s[i] <= d[i], else s[i] holds. Channels are fully independent.
- Output:
  - mode 0: q[i] = s[i], one-cycle latency from d.
  - mode 1: q[i] = en[i] ? d[i] : s[i], combinational from d/en, zero latency.
  - mode may change on any cycle and affects q immediately. It never alters s.
- Snapshot FSM has two states, IDLE and STREAM.
- IDLE:
  - snap_req high at an edge captures snap[i] = en[i] ? d[i] : s[i] for all i, i.e. the post-edge s value.
  - The same edge sets index = 0 and moves to STREAM.
  - snap_busy = 0, out_valid = 0.
- STREAM:
  - snap_busy = 1, out_valid = 1.
  - out_data = snap[index], out_ch = index, out_last = (index == CHANNELS-1).
  - On an edge with out_valid && out_ready: if out_last, go to IDLE; otherwise index increments.
  - With out_ready low, all out_* hold stable. There is no timeout.
  - Stores continue during STREAM and do not affect snap.
- Latency and throughput:
  - First beat is valid in the cycle after the accepting edge.
  - With out_ready held high, a stream takes exactly CHANNELS cycles.
  - At least one IDLE cycle separates streams: snap_req is sampled in IDLE only.
- Dropped requests:
  - Each edge with snap_req high while in STREAM increments drop_cnt.
  - drop_cnt saturates at 2^CNT_W-1 and never wraps.
  - It clears only on reset.
  - A request at the final-beat acceptance edge counts as dropped.
- Reset mid-stream: the stream is abandoned immediately and no further beats are issued.

Test Plan:
- Reset, then mode=0, en=4'b0001, d ch0=8'hA5 for one edge, then en=0 → q ch0=A5 from the next cycle and held while en=0; ch1-3 = 00.
- mode=1, en[2]=1, d ch2 toggles 3C→C3 mid-cycle → q ch2 follows d with no clock; drop en → q ch2 = last value clocked in. Switch to mode=0 → q unchanged.
- Channels loaded 11/22/33/44, pulse snap_req with out_ready=1 → beats (ch0,11),(ch1,22),(ch2,33),(ch3,44+last) on 4 consecutive cycles; then snap_busy=0.
- Same stream with out_ready low for 3 cycles at beat 1, while ch1 is reloaded to 99 → beat 1 holds 22 stable, stream resumes, final data unchanged.
- snap_req held high for a whole 4-beat stream with CNT_W=2 → drop_cnt saturates at 3; next stream starts in the first IDLE cycle.
- rst_n low during beat 2 → all outputs 0 immediately; after release, snap_busy=0 and q=0.
